// File: rtl/vram_shadow.sv
// vram_shadow: mirrors Z80 writes to RAM banks 5/7 into a 32 KB shadow RAM and serves video fetches.
// Optional macro VRAM_FWD_EN forwards queued, not-yet-written bytes to video reads.
`default_nettype none

module vram_shadow #(
  parameter int DEPTH          = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk_sys,
  input  logic        nRESET,
  input  logic        ce_rd,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  input  logic        nMREQ,
  input  logic        nWR,
  input  logic        nRFSH,
  input  logic        m128,
  input  logic [2:0]  page_ram,
  input  logic [14:0] vram_addr,
  output logic [7:0]  vram_dout,
  output logic        busy,
  output logic        ovf,
  output logic [4:0]  level
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         EW      = 23;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  localparam state_e RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

  state_e          state_q, state_d;
  logic [14:0]     clear_ptr_q, clear_ptr_d;
  logic            old_wr_q;
  logic [EW-1:0]   fifo_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [4:0]      count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      dout_q, dout_d;
  logic [7:0]      ram_q [32768];

  logic            wr, cap, hit, bank7;
  logic            pop, push, full_after_pop;
  logic [EW-1:0]   head;
  logic            ram_we;
  logic [14:0]     ram_waddr;
  logic [7:0]      ram_wdata;
  logic [7:0]      rd_byte;

  assign wr  = ~nMREQ & ~nWR & nRFSH;
  assign cap = wr & ~old_wr_q;

  always_comb begin
    hit   = 1'b0;
    bank7 = 1'b0;
    if (addr[15:14] == 2'b01) begin
      hit = 1'b1;
    end else if (addr[15:14] == 2'b11 && m128) begin
      if (page_ram == 3'd5) begin
        hit = 1'b1;
      end else if (page_ram == 3'd7) begin
        hit   = 1'b1;
        bank7 = 1'b1;
      end
    end
  end

  // Reads own the RAM port; the queue only drains once the sweep has finished.
  assign head           = fifo_q[rd_ptr_q];
  assign pop            = (state_q == S_RUN) & ~ce_rd & (count_q != 5'd0);
  assign full_after_pop = (count_q == DEPTH_C) & ~pop;
  assign push           = cap & hit & ~full_after_pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 5'd1;
    end else if (pop && !push) begin
      count_d = count_q - 5'd1;
    end
    ovf_d = ovf_q | (cap & hit & full_after_pop);
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    if (state_q == S_CLEAR && !ce_rd) begin
      clear_ptr_d = clear_ptr_q + 15'd1;
      if (clear_ptr_q == 15'h7FFF) begin
        state_d = S_RUN;
      end
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clear_ptr_q;
    ram_wdata = 8'h00;
    if (!ce_rd) begin
      if (state_q == S_CLEAR) begin
        ram_we = 1'b1;
      end else if (pop) begin
        ram_we    = 1'b1;
        ram_waddr = head[22:8];
        ram_wdata = head[7:0];
      end
    end
  end

`ifdef VRAM_FWD_EN
  logic       fwd_hit;
  logic [7:0] fwd_data;

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      if (5'(i) < count_q && fifo_q[rd_ptr_q + PW'(i)][22:8] == vram_addr) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo_q[rd_ptr_q + PW'(i)][7:0];
      end
    end
  end

  assign rd_byte = fwd_hit ? fwd_data : ram_q[vram_addr];
`else
  assign rd_byte = ram_q[vram_addr];
`endif

  always_comb begin
    dout_d = dout_q;
    if (ce_rd) begin
      dout_d = rd_byte;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (ram_we) begin
      ram_q[ram_waddr] <= ram_wdata;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {bank7, addr[13:0], din};
    end
  end

  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= RST_STATE;
      clear_ptr_q <= 15'd0;
      old_wr_q    <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= 5'd0;
      ovf_q       <= 1'b0;
      dout_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      old_wr_q    <= wr;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      count_q <= count_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
    end
  end

  assign vram_dout = dout_q;
  assign busy      = (state_q == S_CLEAR);
  assign ovf       = ovf_q;
  assign level     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_shadow.sv
// tb_vram_shadow: directed + random stimulus for vram_shadow against a queue/array reference model.
`default_nettype none

module tb_vram_shadow;

  localparam int DEPTH = 4;

  logic        clk_sys = 1'b0;
  logic        nRESET;
  logic        ce_rd;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        nMREQ, nWR, nRFSH, m128;
  logic [2:0]  page_ram;
  logic [14:0] vram_addr;
  logic [7:0]  vram_dout;
  logic        busy, ovf;
  logic [4:0]  level;

  vram_shadow #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (
    .clk_sys(clk_sys), .nRESET(nRESET), .ce_rd(ce_rd), .addr(addr), .din(din),
    .nMREQ(nMREQ), .nWR(nWR), .nRFSH(nRFSH), .m128(m128), .page_ram(page_ram),
    .vram_addr(vram_addr), .vram_dout(vram_dout), .busy(busy), .ovf(ovf), .level(level)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [14:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t       mq[$];
  logic [7:0] mmem [32768];
  int         m_clr;
  bit         m_clearing, m_old_wr, m_ovf;
  logic [7:0] m_dout;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;
  bit dout_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_clr      = 0;
    m_clearing = 1'b1;
    m_old_wr   = 1'b0;
    m_ovf      = 1'b0;
    m_dout     = 8'h00;
  endtask

  task automatic model_edge();
    bit          w, c, h;
    logic [14:0] sa;
    ent_t        e;
    w  = !nMREQ && !nWR && nRFSH;
    c  = w && !m_old_wr;
    m_old_wr = w;
    h  = 1'b0;
    sa = {1'b0, addr[13:0]};
    if (addr[15:14] == 2'b01) h = 1'b1;
    else if (addr[15:14] == 2'b11 && m128 && page_ram == 3'd5) h = 1'b1;
    else if (addr[15:14] == 2'b11 && m128 && page_ram == 3'd7) begin
      h = 1'b1;
      sa[14] = 1'b1;
    end
    if (ce_rd) begin
      m_dout = mmem[vram_addr];
`ifdef VRAM_FWD_EN
      foreach (mq[i]) if (mq[i].a == vram_addr) m_dout = mq[i].d;
`endif
    end else if (m_clearing) begin
      mmem[m_clr] = 8'h00;
      m_clr++;
      if (m_clr == 32768) m_clearing = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      mmem[e.a] = e.d;
    end
    if (c && h) begin
      if (mq.size() < DEPTH) mq.push_back('{a: sa, d: din});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
    if (nRESET) model_edge();
    if (chk_en) begin
      chk("level", 32'(level), 32'(mq.size()));
      chk("busy", 32'(busy), 32'(m_clearing));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (dout_chk) chk("dout", 32'(vram_dout), 32'(m_dout));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; din = d; nMREQ = 1'b0; nWR = 1'b0;
    step();
    step();
    nMREQ = 1'b1; nWR = 1'b1;
    step();
  endtask

  task automatic rd(input logic [14:0] va);
    ce_rd = 1'b1; vram_addr = va;
    step();
    ce_rd = 1'b0;
  endtask

  task automatic assert_reset();
    nRESET = 1'b0;
    #1;
    model_reset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_dout", 32'(vram_dout), 32'd0);
    repeat (2) @(posedge clk_sys);
    #1;
    nRESET = 1'b1;
  endtask

  initial begin
    int cyc;
    nRESET = 1'b0; ce_rd = 1'b0; addr = 16'h0; din = 8'h0;
    nMREQ = 1'b1; nWR = 1'b1; nRFSH = 1'b1; m128 = 1'b0; page_ram = 3'd0; vram_addr = 15'h0;
    model_reset();
    repeat (3) @(posedge clk_sys);
    #1;
    chk("init_level", 32'(level), 32'd0);
    chk("init_busy", 32'(busy), 32'd1);
    chk("init_ovf", 32'(ovf), 32'd0);
    chk("init_dout", 32'(vram_dout), 32'd0);
    nRESET = 1'b1;
    chk_en = 1'b1;

    // Power-on sweep with a video read every 4th cycle
    cyc = 0;
    while (m_clearing && cyc < 50000) begin
      ce_rd = (cyc % 4 == 3);
      vram_addr = 15'(cyc);
      step();
      cyc++;
    end
    ce_rd = 1'b0;
    chk("sweep_cycles", 32'(cyc), 32'd43690);
    chk("sweep_busy_low", 32'(busy), 32'd0);
    dout_chk = 1'b1;
    rd(15'h2ABC);
    chk("clear_2ABC", 32'(vram_dout), 32'h00);

    // Bank 5 write, then fetch
    cpu_write(16'h4000, 8'h5A);
    rd(15'h0000);
    chk("bank5_4000", 32'(vram_dout), 32'h5A);

    // Bank 7 via paging, then unmapped page ignored
    m128 = 1'b1; page_ram = 3'd7;
    cpu_write(16'hD800, 8'h3C);
    idle(2);
    rd(15'h5800);
    chk("bank7_D800", 32'(vram_dout), 32'h3C);
    page_ram = 3'd3;
    cpu_write(16'hD800, 8'h11);
    chk("page3_ignored", 32'(level), 32'd0);
    rd(15'h5800);
    chk("page3_nochange", 32'(vram_dout), 32'h3C);
    m128 = 1'b0;

    // Overflow while reads hold the port
    ce_rd = 1'b1; vram_addr = 15'h0010;
    for (int i = 0; i < 5; i++) cpu_write(16'h4100 + 16'(i), 8'hA0 + 8'(i));
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(ovf), 32'd1);
    ce_rd = 1'b0;
    idle(4);
    chk("drain_level", 32'(level), 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd(15'h0100 + 15'(i));
      chk("drain_data", 32'(vram_dout), 32'hA0 + 32'(i));
    end
    rd(15'h0104);
    chk("dropped_write", 32'(vram_dout), 32'h00);

    // Read of an address with a pending queued write
    ce_rd = 1'b1; vram_addr = 15'h0000;
    cpu_write(16'h4123, 8'h77);
    vram_addr = 15'h0123;
    step();
`ifdef VRAM_FWD_EN
    chk("fwd_read", 32'(vram_dout), 32'h77);
`else
    chk("nofwd_read", 32'(vram_dout), 32'h00);
`endif
    chk("fwd_level", 32'(level), 32'd1);
    ce_rd = 1'b0;
    idle(2);
    rd(15'h0123);
    chk("after_drain_0123", 32'(vram_dout), 32'h77);

    // Random bus traffic
    for (int i = 0; i < 400; i++) begin
      logic [1:0] hi;
      logic [3:0] off;
      hi  = 2'($urandom_range(0, 3));
      off = 4'($urandom_range(0, 15));
      ce_rd    = ($urandom_range(0, 2) == 0);
      nMREQ    = 1'($urandom_range(0, 1));
      nWR      = 1'($urandom_range(0, 1));
      nRFSH    = ($urandom_range(0, 7) != 0);
      m128     = 1'($urandom_range(0, 1));
      page_ram = ($urandom_range(0, 2) == 0) ? 3'd3 : (($urandom_range(0, 1) == 0) ? 3'd5 : 3'd7);
      addr     = {hi, 10'h0, off};
      din      = 8'($urandom);
      vram_addr = {1'($urandom_range(0, 1)), 10'h0, 4'($urandom_range(0, 15))};
      step();
    end
    ce_rd = 1'b0; nMREQ = 1'b1; nWR = 1'b1; nRFSH = 1'b1; m128 = 1'b0;
    idle(DEPTH + 2);
    chk("rand_drained", 32'(level), 32'd0);

    // Reset during sweep with queued writes
    cpu_write(16'h4600, 8'h9C);
    idle(3);
    assert_reset();
    idle(700);
    cpu_write(16'h4700, 8'hE1);
    m128 = 1'b1; page_ram = 3'd7;
    cpu_write(16'hC710, 8'hE2);
    m128 = 1'b0;
    chk("clear_queued", 32'(level), 32'd2);
    idle(290);
    assert_reset();
    idle(200);
    rd(15'h0600);
    chk("sweep_restart", 32'(vram_dout), 32'h9C);
    cyc = 0;
    while (m_clearing && cyc < 40000) begin
      step();
      cyc++;
    end
    chk("sweep2_busy_low", 32'(busy), 32'd0);
    rd(15'h0700);
    chk("discard_0700", 32'(vram_dout), 32'h00);
    rd(15'h4710);
    chk("discard_4710", 32'(vram_dout), 32'h00);
    rd(15'h0600);
    chk("cleared_0600", 32'(vram_dout), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
